// File: rtl/peri_timer.sv
// Memory-mapped 16-bit prescaled timer/compare with one-shot and periodic modes and a level IRQ.
// Register writes take effect at the next posedge; reads are combinational. The block is always ready and has no backpressure.
module peri_timer #(
  parameter logic [7:0] BASE = 8'h10
) (
  input  logic       clk_ip,
  input  logic       reset_n_ip,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic       irq_op
);

  logic [7:0]  off;
  logic        hit;
  logic        wr_ctrl, wr_psc, wr_cmp_l, wr_cmp_h, wr_cnt_l, wr_stat, rd_cnt_l;

  logic        en, irq_en, reload, match;
  logic [7:0]  psc, psc_cnt, snap_h;
  logic [15:0] cmp, cnt;

  logic        psc_hit, stop_wr, tick, fire;
  logic        en_nx, match_nx;
  logic [7:0]  psc_cnt_nx;
  logic [15:0] cnt_nx;

  assign off = addr - BASE;
  assign hit = (addr >= BASE) && (off < 8'd7);

  assign wr_ctrl  = wr_en && hit && (off == 8'd0);
  assign wr_psc   = wr_en && hit && (off == 8'd1);
  assign wr_cmp_l = wr_en && hit && (off == 8'd2);
  assign wr_cmp_h = wr_en && hit && (off == 8'd3);
  assign wr_cnt_l = wr_en && hit && (off == 8'd4);
  assign wr_stat  = wr_en && hit && (off == 8'd6);
  assign rd_cnt_l = rd_en && hit && (off == 8'd4);

  // A stop write or a counter clear on the tick edge swallows that tick.
  always_comb begin
    psc_hit    = en && (psc_cnt == psc);
    stop_wr    = wr_ctrl && !data_in[0];
    tick       = psc_hit && !stop_wr && !wr_cnt_l;
    fire       = tick && (cnt == cmp);

    cnt_nx     = cnt;
    psc_cnt_nx = psc_cnt + 8'd1;
    en_nx      = en;
    match_nx   = match;

    if (wr_cnt_l || fire) begin
      cnt_nx = 16'd0;
    end else if (tick) begin
      cnt_nx = cnt + 16'd1;
    end

    if (!en || stop_wr || wr_cnt_l || psc_hit) begin
      psc_cnt_nx = 8'd0;
    end

    if (wr_ctrl) begin
      en_nx = data_in[0];
    end else if (fire && !reload) begin
      en_nx = 1'b0;
    end

    if (fire) begin
      match_nx = 1'b1;
    end else if (wr_stat && data_in[0]) begin
      match_nx = 1'b0;
    end
  end

  always_ff @(posedge clk_ip or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      reload  <= 1'b0;
      psc     <= 8'd0;
      cmp     <= 16'd0;
      cnt     <= 16'd0;
      psc_cnt <= 8'd0;
      snap_h  <= 8'd0;
      match   <= 1'b0;
      irq_op  <= 1'b0;
    end else begin
      en      <= en_nx;
      cnt     <= cnt_nx;
      psc_cnt <= psc_cnt_nx;
      match   <= match_nx;
      irq_op  <= match && irq_en;
      if (wr_ctrl) begin
        irq_en <= data_in[1];
        reload <= data_in[2];
      end
      if (wr_psc)   psc        <= data_in;
      if (wr_cmp_l) cmp[7:0]   <= data_in;
      if (wr_cmp_h) cmp[15:8]  <= data_in;
      // Snapshot the post-edge high byte so the CNT_L/CNT_H pair stays coherent across a carry.
      if (rd_cnt_l) snap_h     <= cnt_nx[15:8];
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (hit) begin
      case (off)
        8'd0:    data_out = {5'b0, reload, irq_en, en};
        8'd1:    data_out = psc;
        8'd2:    data_out = cmp[7:0];
        8'd3:    data_out = cmp[15:8];
        8'd4:    data_out = cnt[7:0];
        8'd5:    data_out = snap_h;
        8'd6:    data_out = {7'b0, match};
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/peri_timer.md
# peri_timer

Memory-mapped 16-bit timer/compare peripheral that sits on the CPU peripheral bus (8-bit `addr`, separate read/write data, `wr_en`/`rd_en` strobes) as a bus responder. It provides a prescaled up-counter with a compare match, one-shot and auto-reload modes, and a level interrupt output that feeds the CPU `irq_ip` line. It gives firmware periodic interrupts and elapsed-time measurement without busy-wait loops.

## Interface
- `BASE`, 8'h10: register block base address. Must not overlap 8'd3, the CPU-internal IRQ control address; seven registers occupy `BASE` to `BASE`+6.
- `clk_ip` input 1: single clock. All state updates on posedge.
- `reset_n_ip` input 1: asynchronous, active-low reset.
- `addr` input 8: peripheral address from the CPU.
- `data_in` input 8: write data from the CPU (CPU W register).
- `data_out` output 8: read data to the CPU; combinational.
- `wr_en` input 1: write strobe, qualified by `addr`.
- `rd_en` input 1: read strobe, qualified by `addr`.
- `irq_op` output 1: registered interrupt level, high while MATCH and IRQ_EN are both set.

## Operation
Register map (offsets from `BASE`):
- +0 CTRL, rw: bit0 EN, bit1 IRQ_EN, bit2 RELOAD (1 = periodic, 0 = one-shot). Bits 7:3 are read as 0.
- +1 PSC, rw: prescaler. One tick occurs every PSC+1 clocks.
- +2 CMP_L and +3 CMP_H, rw: 16-bit compare value.
- +4 CNT_L, r: live count bits [7:0]. A read latches the high-byte snapshot. Any write clears both `cnt` and `psc_cnt`; the data is ignored.
- +5 CNT_H, r: snapshot `snap_h`. Writes are ignored.
- +6 STAT, r/W1C: bit0 MATCH (sticky). Writing 1 to bit0 clears it.
- Any other address reads 8'h00. Writes to it have no effect.

Counting:
- EN=1: `psc_cnt` increments each clock. When `psc_cnt`==PSC, a tick fires and `psc_cnt` returns to 0.
- On a tick with `cnt`==CMP: `cnt`<=0 and MATCH<=1. If RELOAD=0, EN<=0 (one-shot stop).
- On a tick otherwise: `cnt`<=`cnt`+1, modulo 2^16. 16'hFFFF wraps to 0 and does not set MATCH.
- Period in periodic mode is (CMP+1)*(PSC+1) clocks.
- EN=0: `psc_cnt` is held at 0 and `cnt` holds its value.
- A write of EN=0 takes effect at that edge. A tick coincident with that write is discarded.
- A write to CMP while running takes effect at once. If the new CMP is below `cnt`, the counter runs to 16'hFFFF, wraps, and matches on the next pass.
- Snapshot rule: at the posedge where `rd_en` is high and `addr`==+4, `snap_h` <= the next-state `cnt[15:8]`, meaning the value `cnt` takes at that same edge. This keeps CNT_L and CNT_H consistent across a carry.

Reset values (async, all zero): CTRL, PSC, CMP, `cnt`, `psc_cnt`, `snap_h`, MATCH and `irq_op`.

## Timing
- The CPU changes `addr`, strobes and `data_in` after the negedge. This block samples writes and read side-effects at the following posedge.
- `data_out` is a combinational function of `addr` and register state. It must settle before the next negedge, where the CPU captures it.
- Write-to-effect latency is 1 posedge.
- MATCH sets at the tick edge. `irq_op` rises one posedge later. After MATCH or IRQ_EN clears, `irq_op` falls one posedge later.
- Same-edge conflicts:
  - A STAT W1C on the same edge as a new match: the set wins and MATCH stays 1.
  - A CNT_L write on the same edge as a tick: the write wins, and `cnt` and `psc_cnt` become 0.
  - A CTRL write on the same edge as a one-shot stop: the written EN value wins.
- Reset asserted mid-count immediately clears all state and forces `irq_op` to 0. Counting does not resume until CTRL is written.

## Test plan
- Reset, then read +0 to +6: all return 8'h00 and `irq_op`=0. Read `BASE`+7 and addr 8'd3: both return 8'h00. Write addr 3: no register changes.
- PSC=3, CMP=16'h0004, CTRL=8'h07: MATCH sets at exactly 20 clocks after the EN write edge. `irq_op` rises 1 clock later, and matches repeat every 20 clocks.
- One-shot: CTRL=8'h03, PSC=0, CMP=2. MATCH sets after 3 clocks, CTRL reads 8'h02, and `cnt` stays 0.
- W1C: with MATCH=1 and no match pending, write STAT=8'h01. MATCH reads 0 and `irq_op` falls 1 clock later. Repeat with the write on a match edge: MATCH stays 1.
- Snapshot across carry: PSC=0, CMP=16'hFFFF, running. Read CNT_L on the edge where `cnt` goes 16'h00FF to 16'h0100, then read CNT_H. The pair returns 8'h00 then 8'h01.
- Assert `reset_n_ip` mid-count between clock edges: all outputs and registers are 0 immediately, with no tick after release.
